// File: rtl/tia_pkg.sv
// ---------------------------------------------------------------------------
// tia_pkg
//
// Shared definitions for the TIA horizontal phase sequencer:
//   - END_CNT_DEFAULT : default last horizontal LFSR value before wrap
//   - ph_oh_e         : one-hot phase encodings (phase 0..3)
//   - lfsr_step()     : one step of the 6-bit horizontal polynomial counter
// ---------------------------------------------------------------------------
package tia_pkg;

   // Last LFSR value of a line; the count after it is forced back to zero.
   localparam logic [5:0] END_CNT_DEFAULT = 6'b010100;

   // Width of the horizontal counter.
   localparam int HCNT_W = 6;

   // One-hot phase state. Bit 0 drives s1, bit 2 drives s2; bits 1 and 3
   // are the guard phases that keep the two clocks apart.
   typedef enum logic [3:0] {
      PH_0 = 4'b0001,
      PH_1 = 4'b0010,
      PH_2 = 4'b0100,
      PH_3 = 4'b1000
   } ph_oh_e;

   // XNOR-feedback shift: new LSB is the inverted XOR of the top two bits.
   // All-zero is a legal state for XNOR feedback, so the counter can start
   // from 000000 after reset or resync.
   function automatic logic [HCNT_W-1:0] lfsr_step(input logic [HCNT_W-1:0] h);
      lfsr_step = {h[4:0], ~(h[5] ^ h[4])};
   endfunction

endpackage : tia_pkg

// File: rtl/tia_hlfsr.sv
// ---------------------------------------------------------------------------
// tia_hlfsr
//
// Horizontal polynomial counter with end-of-line decode.
//
// Ports:
//   clk    in   color clock
//   rst_n  in   asynchronous active-low reset
//   adv    in   advance request (edge leaving phase 3)
//   clr    in   synchronous clear (resync); has priority over adv
//   hcount out  6-bit LFSR count
//   wrap   out  registered one-clk pulse, high while hcount holds the
//               000000 that was just loaded by an end-of-line wrap
// ---------------------------------------------------------------------------
module tia_hlfsr
   import tia_pkg::*;
#(
   parameter logic [5:0] END_CNT = END_CNT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   input  logic              clr,
   output logic [HCNT_W-1:0] hcount,
   output logic              wrap
);

   logic [HCNT_W-1:0] hcount_nxt;
   logic              wrap_nxt;
   logic              at_end;

   assign at_end = (hcount == END_CNT);

   // wrap is only ever set on an advancing edge; every other edge clears
   // it, which makes it exactly one clk wide (the following phase 0).
   always_comb begin
      hcount_nxt = hcount;
      wrap_nxt   = 1'b0;
      if (clr) begin
         // Resync wins over a coincident wrap: count cleared, no pulse.
         hcount_nxt = '0;
         wrap_nxt   = 1'b0;
      end else if (adv) begin
         if (at_end) begin
            hcount_nxt = '0;
            wrap_nxt   = 1'b1;
         end else begin
            hcount_nxt = lfsr_step(hcount);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount <= '0;
         wrap   <= 1'b0;
      end else begin
         hcount <= hcount_nxt;
         wrap   <= wrap_nxt;
      end
   end

endmodule : tia_hlfsr

// File: rtl/tia_hphase_seq.sv
// ---------------------------------------------------------------------------
// tia_hphase_seq
//
// Four-phase two-clock generator for the TIA horizontal logic, plus the
// horizontal LFSR counter that advances once per four color clocks.
//
// Ports:
//   clk    in   color clock
//   rst_n  in   asynchronous active-low reset
//   rsync  in   synchronous resync strobe (forces phase 0, count 0)
//   s1     out  phase-1 clock, one clk high per 4-clk period (phase 0)
//   s2     out  phase-2 clock, one clk high per 4-clk period (phase 2)
//   phase  out  binary phase index 0..3
//   hcount out  6-bit horizontal LFSR count
//   wrap   out  one-clk start-of-line pulse, coincident with s1
// ---------------------------------------------------------------------------
module tia_hphase_seq
   import tia_pkg::*;
#(
   parameter logic [5:0] END_CNT = END_CNT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rsync,
   output logic              s1,
   output logic              s2,
   output logic [1:0]        phase,
   output logic [HCNT_W-1:0] hcount,
   output logic              wrap
);

   ph_oh_e ph_q;
   ph_oh_e ph_nxt;
   logic   adv;

   // Next phase: rotate one position per edge. Any pattern outside the
   // four legal one-hot codes falls to the default and restarts at PH_0.
   always_comb begin
      ph_nxt = PH_0;
      if (rsync) begin
         ph_nxt = PH_0;
      end else begin
         case (ph_q)
            PH_0:    ph_nxt = PH_1;
            PH_1:    ph_nxt = PH_2;
            PH_2:    ph_nxt = PH_3;
            PH_3:    ph_nxt = PH_0;
            default: ph_nxt = PH_0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_q <= PH_0;
      end else begin
         ph_q <= ph_nxt;
      end
   end

   // Clocks come straight off the state flops so they are glitch-free;
   // phases 1 and 3 keep them at least one clk apart on both sides.
   assign s1 = ph_q[0];
   assign s2 = ph_q[2];

   always_comb begin
      phase = 2'd0;
      case (ph_q)
         PH_1:    phase = 2'd1;
         PH_2:    phase = 2'd2;
         PH_3:    phase = 2'd3;
         default: phase = 2'd0;
      endcase
   end

   // The counter steps on the edge leaving phase 3, unless a resync on the
   // same edge is clearing everything.
   assign adv = ph_q[3] & ~rsync;

   tia_hlfsr #(
      .END_CNT (END_CNT)
   ) u_hlfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv    (adv),
      .clr    (rsync),
      .hcount (hcount),
      .wrap   (wrap)
   );

endmodule : tia_hphase_seq

// File: doc/tia_hphase_seq.md
TIA_HPHASE_SEQ -- requirements
Module: tia_hphase_seq

Interface
REQ-001 Parameter END_CNT, default 6'b010100, is the hcount value after which the horizontal LFSR wraps to 000000.
REQ-002 clk  in  1  color clock; single clock domain, all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 rsync  in  1  synchronous resync request (RSYNC strobe), sampled on posedge clk.
REQ-005 s1  out  1  phase-1 clock for D1 stages; one clk high per 4-clk period.
REQ-006 s2  out  1  phase-2 clock for D1 stages; one clk high per 4-clk period, never overlapping s1.
REQ-007 phase  out  2  current phase index 0..3, binary.
REQ-008 hcount  out  6  horizontal polynomial (LFSR) count.
REQ-009 wrap  out  1  one-clk pulse marking start of a new line (hcount just loaded 000000 by wrap).

Function
REQ-010 Phase state SHALL be a 4-bit one-hot register stepping 0001->0010->0100->1000->0001 on every clk edge, absent rsync.
REQ-011 s1 SHALL equal one-hot bit 0 and s2 SHALL equal one-hot bit 2, driven directly from flops, no combinational decode.
REQ-012 s1 and s2 SHALL always be separated by at least one clk low on both sides (phases 1 and 3 are guard phases).
REQ-013 phase SHALL be the binary encoding of the one-hot state, 0 when s1 high, 2 when s2 high.
REQ-014 hcount SHALL change only on the edge leaving phase 3 (entering phase 0), at most once per 4 clks.
REQ-015 LFSR step: hcount_next = {hcount[4:0], ~(hcount[5] ^ hcount[4])}.
REQ-016 If hcount == END_CNT on an advancing edge, hcount SHALL load 6'b000000 instead of the LFSR step, and wrap SHALL be set.
REQ-017 wrap SHALL be registered, high exactly for the phase-0 clk following the wrap load, low otherwise.
REQ-018 rsync high at an edge SHALL force one-hot to 0001, hcount to 000000, wrap to 0, regardless of current phase.
REQ-019 rsync coincident with a wrap edge: rsync wins, wrap SHALL stay 0.
REQ-020 rsync held high for N clks SHALL hold phase 0 / hcount 0 for N clks; stepping resumes on the first edge with rsync low (-> phase 1).
REQ-021 Illegal one-hot state (unreachable) SHALL recover to 0001 on the next edge.

Reset
REQ-022 rst_n low SHALL immediately set one-hot 0001 (s1=1, s2=0, phase=0), hcount 000000, wrap 0.
REQ-023 Reset assertion mid-period SHALL abort the period with no further s1/s2 pulses; deassertion SHALL be sampled synchronously, first edge after deassert enters phase 1.

Structure
REQ-024 A shared package tia_pkg SHALL hold the default END_CNT constant, the one-hot phase constants, and the LFSR step function.
REQ-025 The LFSR with wrap decode SHALL be one sub-module tia_hlfsr (inputs clk, rst_n, adv, clr; outputs hcount, wrap); phase logic stays in the top.

Verification
REQ-026 Reset then 8 free clks -> s1 pattern 1,0,0,0,1,0,0,0; s2 pattern 0,0,1,0,0,0,1,0; never s1&s2.
REQ-027 From reset, hcount after 4, 8, 12, 16 clks -> 000001, 000011, 000111, 001111.
REQ-028 Free-run to wrap -> wrap pulses once per (LFSR states through END_CNT)x4 clks, matching the package-function model; hcount 000000 while wrap high, coincident with s1.
REQ-029 Assert rsync 1 clk during phase 2 with hcount 000111 -> next clk phase 0, s1=1, hcount 000000, wrap 0; next clk phase 1.
REQ-030 rsync on the edge where hcount == END_CNT would wrap -> hcount 000000, wrap stays 0.
REQ-031 rst_n pulsed low asynchronously mid-phase 2 -> s2 drops and s1 rises without a clk edge, hcount 000000.
